// File: rtl/fifo_pop_arbiter.sv
// fifo_pop_arbiter
// Round-robin pop arbiter across NUM_REQ upstream FIFOs. The winning head word
// is parity-checked on the way into a single output register. Words that fail
// parity are popped and dropped, and an error pulse is raised. A requester that
// fails ERR_LIMIT times in a row is masked until clear_i.
module fifo_pop_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 9,
  parameter     PARITY_BIT  = "MSB",
  parameter     PARITY_TYPE = "EVEN",
  parameter int ERR_LIMIT   = 3,
  parameter int CNT_WIDTH   = 16,
  localparam int SRC_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            pop_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] pop_data_i,
  output logic [NUM_REQ-1:0]            pop_grant_o,
  output logic                          valid_o,
  output logic [DATA_WIDTH-2:0]         data_o,
  output logic [SRC_W-1:0]              src_o,
  input  logic                          grant_i,
  output logic                          err_o,
  output logic [SRC_W-1:0]              err_src_o,
  output logic [CNT_WIDTH-1:0]          err_cnt_o,
  output logic [NUM_REQ-1:0]            mask_o,
  input  logic                          clear_i
);

  // The consecutive-error counter only has to reach ERR_LIMIT, then it saturates.
  localparam int CE_W = (ERR_LIMIT < 2) ? 1 : $clog2(ERR_LIMIT + 1);
  localparam logic [CE_W-1:0] CE_LIMIT = CE_W'(ERR_LIMIT);
  localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(NUM_REQ - 1);
  localparam bit PAR_ODD = (PARITY_TYPE == "ODD");

  logic                  valid_q;
  logic [DATA_WIDTH-2:0] data_q;
  logic [SRC_W-1:0]      src_q;
  logic                  err_q;
  logic [SRC_W-1:0]      err_src_q;
  logic [CNT_WIDTH-1:0]  err_cnt_q;
  logic [NUM_REQ-1:0]    mask_q;
  logic [SRC_W-1:0]      rr_ptr_q;
  logic [CE_W-1:0]       cerr_q [NUM_REQ];

  logic [DATA_WIDTH-1:0] words   [NUM_REQ];
  logic [NUM_REQ-1:0]    eligible;
  logic                  slot_free;
  logic                  win_found;
  logic [SRC_W-1:0]      win_idx;
  logic [SRC_W-1:0]      rr_next;
  logic                  pop_fire;
  logic [DATA_WIDTH-1:0] win_word;
  logic [DATA_WIDTH-2:0] win_payload;
  logic                  par_ok;
  logic                  pop_err;

  // Split the flat data bus into per-requester head words.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      words[i] = pop_data_i[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign eligible  = pop_valid_i & ~mask_q;
  assign slot_free = !valid_q || grant_i;

  // Round-robin pick: first eligible index at or above rr_ptr, wrapping.
  always_comb begin
    int               idx;
    logic [SRC_W-1:0] idx_w;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    idx_w     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx   = (int'(rr_ptr_q) + k) % NUM_REQ;
      idx_w = SRC_W'(idx);
      if (!win_found && eligible[idx_w]) begin
        win_found = 1'b1;
        win_idx   = idx_w;
      end
    end
  end

  assign rr_next = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;

  // Reset gates the strobe directly so no FIFO is popped while rst_n is low.
  assign pop_fire    = rst_n && slot_free && !clear_i && win_found;
  assign pop_grant_o = pop_fire ? (NUM_REQ'(1) << win_idx) : '0;

  assign win_word = words[win_idx];
  assign par_ok   = (^win_word) == PAR_ODD;
  assign pop_err  = pop_fire && !par_ok;

  generate
    if (PARITY_BIT == "LSB") begin : g_par_lsb
      assign win_payload = win_word[DATA_WIDTH-1:1];
    end else begin : g_par_msb
      assign win_payload = win_word[DATA_WIDTH-2:0];
    end
  endgenerate

  // Output register: load a good word, drain on accept, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      src_q   <= '0;
    end else if (pop_fire && par_ok) begin
      valid_q <= 1'b1;
      data_q  <= win_payload;
      src_q   <= win_idx;
    end else if (slot_free) begin
      valid_q <= 1'b0;
    end
  end

  // Error pulse, last-error source and saturating total error count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q     <= 1'b0;
      err_src_q <= '0;
      err_cnt_q <= '0;
    end else begin
      err_q <= pop_err;
      if (pop_err) begin
        err_src_q <= win_idx;
      end
      if (clear_i) begin
        err_cnt_q <= '0;
      end else if (pop_err && !(&err_cnt_q)) begin
        err_cnt_q <= err_cnt_q + 1'b1;
      end
    end
  end

  // Per-requester consecutive-error tracking and masking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        cerr_q[i] <= '0;
      end
    end else if (clear_i) begin
      mask_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        cerr_q[i] <= '0;
      end
    end else if (pop_fire) begin
      if (par_ok) begin
        cerr_q[win_idx] <= '0;
      end else begin
        if (cerr_q[win_idx] < CE_LIMIT) begin
          cerr_q[win_idx] <= cerr_q[win_idx] + 1'b1;
        end
        if (cerr_q[win_idx] >= CE_LIMIT - 1'b1) begin
          mask_q[win_idx] <= 1'b1;
        end
      end
    end
  end

  // Round-robin pointer advances past every winner, good word or bad.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else if (pop_fire) begin
      rr_ptr_q <= rr_next;
    end
  end

  assign valid_o   = valid_q;
  assign data_o    = data_q;
  assign src_o     = src_q;
  assign err_o     = err_q;
  assign err_src_o = err_src_q;
  assign err_cnt_o = err_cnt_q;
  assign mask_o    = mask_q;

endmodule

// File: tb/tb_fifo_pop_arbiter.sv
// Directed bench for fifo_pop_arbiter at default parameters.
module tb_fifo_pop_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  pop_valid;
  logic [35:0] pop_data;
  logic [3:0]  pop_grant;
  logic        valid;
  logic [7:0]  data;
  logic [1:0]  src;
  logic        grant;
  logic        err;
  logic [1:0]  err_src;
  logic [15:0] err_cnt;
  logic [3:0]  mask;
  logic        clear;
  logic [8:0]  w [4];

  int errors = 0;
  int checks = 0;

  assign pop_data = {w[3], w[2], w[1], w[0]};

  fifo_pop_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pop_valid_i (pop_valid),
    .pop_data_i  (pop_data),
    .pop_grant_o (pop_grant),
    .valid_o     (valid),
    .data_o      (data),
    .src_o       (src),
    .grant_i     (grant),
    .err_o       (err),
    .err_src_o   (err_src),
    .err_cnt_o   (err_cnt),
    .mask_o      (mask),
    .clear_i     (clear)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; grant = 1'b0; clear = 1'b0; pop_valid = 4'b1111;
    w[0] = 9'h003; w[1] = 9'h005; w[2] = 9'h006; w[3] = 9'h009;
    #1;
    chk("rst_grant", 32'(pop_grant), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_data", 32'(data), 32'h0);
    chk("rst_errcnt", 32'(err_cnt), 32'h0);
    chk("rst_mask", 32'(mask), 32'h0);
    tick(); tick();
    rst_n = 1'b1;

    // Round robin across four good heads
    grant = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("rr_grant%0d", k), 32'(pop_grant), 32'h1 << (k % 4));
      tick();
      chk($sformatf("rr_src%0d", k), 32'(src), 32'(k % 4));
      chk($sformatf("rr_data%0d", k), 32'(data), 32'(w[k % 4][7:0]));
    end

    // Single requester, one-cycle latency (pointer at 1 wraps back to 0)
    pop_valid = 4'b0001;
    #1 chk("single_grant", 32'(pop_grant), 32'h1);
    tick();
    chk("single_valid", 32'(valid), 32'h1);
    chk("single_data", 32'(data), 32'h03);
    chk("single_src", 32'(src), 32'h0);
    pop_valid = 4'b0000;
    tick();
    chk("drain_valid", 32'(valid), 32'h0);

    // Parity failure from FIFO2
    w[2] = 9'h103; pop_valid = 4'b0100;
    #1 chk("bad_grant", 32'(pop_grant), 32'h4);
    tick();
    chk("bad_err", 32'(err), 32'h1);
    chk("bad_errsrc", 32'(err_src), 32'h2);
    chk("bad_errcnt", 32'(err_cnt), 32'h1);
    chk("bad_valid", 32'(valid), 32'h0);
    pop_valid = 4'b0000;
    tick();
    chk("err_pulse_end", 32'(err), 32'h0);
    chk("errsrc_hold", 32'(err_src), 32'h2);

    // Three consecutive bad words from FIFO1 mask it
    w[1] = 9'h103; pop_valid = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("mask_grant%0d", k), 32'(pop_grant), 32'h2);
      tick();
      chk($sformatf("mask_errcnt%0d", k), 32'(err_cnt), 32'(k + 2));
      chk($sformatf("mask_val%0d", k), 32'(mask), (k == 2) ? 32'h2 : 32'h0);
    end
    #1 chk("masked_nogrant", 32'(pop_grant), 32'h0);
    pop_valid = 4'b0011;
    #1 chk("masked_skip", 32'(pop_grant), 32'h1);
    clear = 1'b1;
    #1 chk("clear_nogrant", 32'(pop_grant), 32'h0);
    tick();
    clear = 1'b0;
    chk("clear_mask", 32'(mask), 32'h0);
    chk("clear_errcnt", 32'(err_cnt), 32'h0);
    w[1] = 9'h005; pop_valid = 4'b0010;
    #1 chk("unmask_grant", 32'(pop_grant), 32'h2);
    tick();
    chk("unmask_data", 32'(data), 32'h05);
    chk("unmask_src", 32'(src), 32'h1);

    // Backpressure: hold output, no pops
    grant = 1'b0; pop_valid = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      #1 chk($sformatf("bp_grant%0d", k), 32'(pop_grant), 32'h0);
      tick();
      chk($sformatf("bp_data%0d", k), 32'(data), 32'h05);
      chk($sformatf("bp_valid%0d", k), 32'(valid), 32'h1);
    end
    grant = 1'b1;
    #1 chk("bp_release_grant", 32'(pop_grant), 32'h8);
    tick();
    chk("bp_release_data", 32'(data), 32'h09);
    chk("bp_release_src", 32'(src), 32'h3);

    // Move pointer to 2, then reset mid-transfer
    pop_valid = 4'b0010;
    #1 chk("pre_rst_grant", 32'(pop_grant), 32'h2);
    tick();
    grant = 1'b0; pop_valid = 4'b1110;
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(valid), 32'h0);
    chk("mid_rst_data", 32'(data), 32'h0);
    chk("mid_rst_grant", 32'(pop_grant), 32'h0);
    tick();
    rst_n = 1'b1; grant = 1'b1; pop_valid = 4'b0110;
    #1 chk("post_rst_grant", 32'(pop_grant), 32'h2);
    tick();
    chk("post_rst_data", 32'(data), 32'h05);

    // A good pop between bad ones restarts the consecutive count
    pop_valid = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      w[1] = (k == 2) ? 9'h005 : 9'h103;
      tick();
    end
    chk("streak_mask", 32'(mask), 32'h0);
    chk("streak_errcnt", 32'(err_cnt), 32'h4);
    w[1] = 9'h103;
    tick();
    chk("streak_mask3", 32'(mask), 32'h2);
    pop_valid = 4'b0000;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_pop_arbiter.md
FIFO_POP_ARBITER -- requirements
Module: fifo_pop_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of upstream FIFO pop ports (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 9, width of each FIFO word including its parity bit.
REQ-003 SHALL have parameter PARITY_BIT, default "MSB", parity bit position ("MSB" = bit DATA_WIDTH-1, "LSB" = bit 0).
REQ-004 SHALL have parameter PARITY_TYPE, default "EVEN", meaning the XOR of all DATA_WIDTH bits is 0 ("ODD": XOR is 1).
REQ-005 SHALL have parameter ERR_LIMIT, default 3, consecutive parity errors that mask a requester.
REQ-006 SHALL have parameter CNT_WIDTH, default 16, width of the error counter.
REQ-007 clk  in  1  single clock; all state on rising edge.
REQ-008 rst_n  in  1  reset, asynchronous, active-low.
REQ-009 pop_valid_i  in  NUM_REQ  bit i = FIFO i is non-empty.
REQ-010 pop_data_i  in  NUM_REQ*DATA_WIDTH  FIFO i head word at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-011 pop_grant_o  in/out: out  NUM_REQ  one-hot pop strobe to FIFO i; head consumed on that edge.
REQ-012 valid_o  out  1  output register holds a checked word.
REQ-013 data_o  out  DATA_WIDTH-1  word with parity bit removed.
REQ-014 src_o  out  $clog2(NUM_REQ)  index of the requester that supplied data_o.
REQ-015 grant_i  in  1  downstream accepts data_o when valid_o && grant_i.
REQ-016 err_o  out  1  one-cycle pulse: a popped word failed parity.
REQ-017 err_src_o  out  $clog2(NUM_REQ)  requester index of the last error, held until the next error.
REQ-018 err_cnt_o  out  CNT_WIDTH  total parity errors, saturating at all-ones.
REQ-019 mask_o  out  NUM_REQ  bit i = requester i disabled by the error limit.
REQ-020 clear_i  in  1  synchronous: zeroes err_cnt_o, mask_o, and the consecutive-error counters.

Function
REQ-021 Slot is free when valid_o==0, or valid_o && grant_i in the same cycle.
REQ-022 Eligible set SHALL be pop_valid_i & ~mask_o; when the slot is free and the set is non-empty, exactly one pop_grant_o bit SHALL be high, combinationally, in that cycle.
REQ-023 Selection SHALL be round-robin: the first eligible index at or above rr_ptr, wrapping modulo NUM_REQ; rr_ptr SHALL become winner+1 (mod NUM_REQ) after every grant.
REQ-024 pop_grant_o SHALL be all-zero when the slot is not free, the eligible set is empty, or clear_i is high.
REQ-025 Granted word passing parity SHALL be loaded on the next edge: valid_o=1, data_o=payload (the other DATA_WIDTH-1 bits, order kept), src_o=winner; latency is 1 cycle from pop to valid_o.
REQ-026 Granted word failing parity SHALL be dropped (still popped): next cycle err_o=1, err_src_o=winner, err_cnt_o+1 (saturating); valid_o SHALL be 0 unless a simultaneous accept left it 0 already.
REQ-027 If a free slot is caused by accept and no eligible request exists, valid_o SHALL fall to 0 on the next edge.
REQ-028 Each requester SHALL have a consecutive-error counter: +1 on its failing pop, cleared on its passing pop; reaching ERR_LIMIT SHALL set mask_o[i] on the same edge as err_o.
REQ-029 data_o/src_o SHALL stay stable while valid_o && !grant_i.
REQ-030 clear_i wins over a simultaneous error: counters and mask are zeroed and no increment occurs.
REQ-031 All-masked or all-empty: idle, no grants, output drains normally.

Reset
REQ-032 On rst_n low, immediately: valid_o=0, data_o=0, src_o=0, err_o=0, err_src_o=0, err_cnt_o=0, mask_o=0, rr_ptr=0, consecutive counters=0; pop_grant_o=0 while reset is asserted.
REQ-033 Reset mid-transfer SHALL discard the held word; the first grant after release SHALL go to the lowest eligible index.

Verification (defaults)
REQ-034 FIFO0 head 0x003, grant_i=1 -> pop_grant_o=0001 in cycle 0; cycle 1: valid_o=1, data_o=0x03, src_o=0.
REQ-035 All four valid with good words, grant_i=1 -> grants 0001,0010,0100,1000,0001 on consecutive cycles.
REQ-036 FIFO2 head 0x103 -> popped; next cycle err_o=1, err_src_o=2, err_cnt_o=1, valid_o=0.
REQ-037 Three consecutive bad words from FIFO1 -> mask_o=0010 after the third; FIFO1 is then never granted; clear_i -> mask_o=0000, err_cnt_o=0.
REQ-038 valid_o=1 and grant_i=0 for 5 cycles with FIFO3 valid -> no pop_grant_o; data_o stable; on grant_i=1, FIFO3 is granted in that same cycle.
REQ-039 rst_n low during valid_o=1 -> valid_o=0 at once; after release, first grant goes to the lowest valid index.
